// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot-time loader. It receives a program as a big-endian byte stream and
// writes it word by word into the processor's instruction memory. The
// processor is held in reset while the loader runs. It is released only after
// the trailing checksum matches.
//
// Stream format: count[15:8], count[7:0], count x 4 data bytes, checksum.
// The checksum is the XOR of all data bytes. The count bytes are not part of
// the XOR.
//
// Ports
//   clk           in   1   system clock, rising edge
//   reset         in   1   synchronous, active-low
//   load_req      in   1   one-cycle pulse; starts a new load from RUN/ERROR
//   rx_data       in   8   stream byte
//   rx_valid      in   1   rx_data valid
//   rx_ready      out  1   loader can accept a byte (decoded from state)
//   mem_we        out  1   instruction-memory write strobe, one cycle per word
//   mem_addr      out  32  byte address of the word being written
//   mem_wdata     out  32  word being written
//   cpu_reset     out  1   active-low processor reset (0 = held in reset)
//   busy          out  1   load in progress
//   done          out  1   load completed with a good checksum
//   error         out  1   load rejected (bad checksum or oversize count)
//   words_loaded  out  16  words written in the current load
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        RUN,
        ERROR
    } stateT;

    stateT       state;
    stateT       nextState;

    logic [7:0]  lenHi;        // count[15:8], held until count[7:0] arrives
    logic [15:0] wordCount;    // total words announced by the stream
    logic [15:0] wordIdx;      // index of the word being assembled
    logic [1:0]  byteIdx;      // byte position within the current word
    logic [23:0] shiftReg;     // first three bytes of the current word
    logic [7:0]  xorAcc;       // running XOR of data bytes
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [15:0] wordsLoaded;

    logic        accept;
    logic [15:0] lenValue;
    logic        lastByteOfWord;
    logic        lastWord;

    assign accept         = rx_valid && rx_ready;
    assign lenValue       = {lenHi, rx_data};
    assign lastByteOfWord = (byteIdx == 2'd3);
    assign lastWord       = ((wordIdx + 16'd1) == wordCount);

    // -----------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so that no path through the
        // case leaves a signal unassigned. An unassigned path would infer a latch.
        nextState = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b0;

        case (state)
            LEN_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) nextState = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    if (lenValue == 16'd0)
                        nextState = CHECK;
                    else if ({16'd0, lenValue} > 32'(MEMORY_DEPTH))
                        nextState = ERROR;
                    else
                        nextState = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && lastByteOfWord && lastWord) nextState = CHECK;
            end
            CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) nextState = (rx_data == xorAcc) ? RUN : ERROR;
            end
            RUN: begin
                done      = 1'b1;
                cpu_reset = 1'b1;
                if (load_req) nextState = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (load_req) nextState = LEN_HI;
            end
            default: nextState = LEN_HI;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) only. All
    // registers then sample pre-edge values, and simulation matches the
    // synthesised flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= LEN_HI;
            lenHi       <= '0;
            wordCount   <= '0;
            wordIdx     <= '0;
            byteIdx     <= '0;
            shiftReg    <= '0;
            xorAcc      <= '0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            wordsLoaded <= '0;
        end else begin
            state <= nextState;
            memWe <= 1'b0;

            // The counter follows the write strobe. It shows the new total
            // from the edge after the write cycle.
            if (memWe) wordsLoaded <= wordsLoaded + 16'd1;

            case (state)
                LEN_HI: if (accept) lenHi <= rx_data;
                LEN_LO: if (accept) wordCount <= lenValue;
                DATA: begin
                    if (accept) begin
                        xorAcc <= xorAcc ^ rx_data;
                        if (lastByteOfWord) begin
                            // The write register is separate from the assembly
                            // register. The next word can start filling while
                            // this one issues.
                            memWe    <= 1'b1;
                            memAddr  <= {14'd0, wordIdx, 2'b00};
                            memWdata <= {shiftReg, rx_data};
                            wordIdx  <= wordIdx + 16'd1;
                            byteIdx  <= 2'd0;
                        end else begin
                            shiftReg <= {shiftReg[15:0], rx_data};
                            byteIdx  <= byteIdx + 2'd1;
                        end
                    end
                end
                RUN, ERROR: begin
                    if (load_req) begin
                        wordsLoaded <= '0;
                        xorAcc      <= '0;
                        byteIdx     <= '0;
                        wordIdx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we       = memWe;
    assign mem_addr     = memAddr;
    assign mem_wdata    = memWdata;
    assign words_loaded = wordsLoaded;

endmodule
